// File: rtl/elder_vitals_pkg.sv
// Shared constants and helpers for the elderly-care vitals core.
// Holds the bpm width and saturation value, the default thresholds and
// periods used as parameter defaults by the core, and a saturating
// increment used by the beat counter.
package elder_vitals_pkg;

  localparam int BPM_W = 5;
  localparam logic [BPM_W-1:0] BPM_MAX = 5'd31;

  localparam int DEF_FALL_CYCLES   = 3;
  localparam int DEF_FALL_HOLD     = 4;
  localparam int DEF_WINDOW_CYCLES = 64;
  localparam int DEF_BPM_LOW       = 6;
  localparam int DEF_BPM_HIGH      = 20;
  localparam int DEF_REMIND_PERIOD = 100;
  localparam int DEF_REMIND_WIDTH  = 10;

  // Adds one when inc is set, but never wraps past BPM_MAX.
  function automatic logic [BPM_W-1:0] sat_inc(input logic [BPM_W-1:0] value,
                                               input logic inc);
    if (inc && (value != BPM_MAX)) begin
      return value + BPM_W'(1);
    end
    return value;
  endfunction

endpackage

// File: rtl/elder_vitals_bpm_window_counter.sv
// Heartbeat-rate estimator.
// Counts rising edges of mono_pulse over a fixed window of WINDOW_CYCLES
// clocks and publishes the (saturated) count at the end of each window,
// together with a flag that is set when the count is outside
// [BPM_LOW, BPM_HIGH]. bpm and bpm_state hold between window ends.
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-low reset
//   mono_pulse in   heartbeat pulse level
//   bpm        out  beats counted in the last completed window
//   bpm_state  out  1 = last bpm outside the normal band
module bpm_window_counter
  import elder_vitals_pkg::*;
#(
  parameter int WINDOW_CYCLES = DEF_WINDOW_CYCLES,
  parameter int BPM_LOW       = DEF_BPM_LOW,
  parameter int BPM_HIGH      = DEF_BPM_HIGH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mono_pulse,
  output logic [BPM_W-1:0] bpm,
  output logic             bpm_state
);

  localparam int WIN_W = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
  localparam logic [BPM_W-1:0] LOW_T    = BPM_W'(BPM_LOW);
  localparam logic [BPM_W-1:0] HIGH_T   = BPM_W'(BPM_HIGH);

  logic             mono_prev;
  logic [WIN_W-1:0] win_cnt;
  logic [BPM_W-1:0] beat_cnt;
  logic             rise;
  logic             win_wrap;
  logic [BPM_W-1:0] beat_total;

  // beat_total already includes an edge landing on the wrap cycle, so the
  // published value never loses the last beat of a window.
  always_comb begin
    rise       = mono_pulse & ~mono_prev;
    win_wrap   = (win_cnt == WIN_LAST);
    beat_total = sat_inc(beat_cnt, rise);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mono_prev <= 1'b0;
      win_cnt   <= '0;
      beat_cnt  <= '0;
      bpm       <= '0;
      bpm_state <= 1'b0;
    end else begin
      mono_prev <= mono_pulse;
      if (win_wrap) begin
        win_cnt   <= '0;
        beat_cnt  <= '0;
        bpm       <= beat_total;
        bpm_state <= (beat_total < LOW_T) || (beat_total > HIGH_T);
      end else begin
        win_cnt   <= win_cnt + WIN_W'(1);
        beat_cnt  <= beat_total;
      end
    end
  end

endmodule

// File: rtl/elder_vitals_core.sv
// Synchronous core of the elderly-care monitor: fall alarm, heartbeat-rate
// estimator and periodic medicine reminder, all independent on one clock.
// Ports:
//   clk               in   rising-edge clock
//   reset             in   asynchronous, active-low reset
//   fall_detector     in   raw fall-sensor level
//   mono_pulse        in   heartbeat pulse level
//   fall_state        out  fall alarm (registered)
//   bpm               out  beats in the last completed window
//   bpm_state         out  1 = bpm outside the normal band
//   medicine_reminder out  periodic reminder pulse (registered)
module elder_vitals_core
  import elder_vitals_pkg::*;
#(
  parameter int FALL_CYCLES   = DEF_FALL_CYCLES,
  parameter int FALL_HOLD     = DEF_FALL_HOLD,
  parameter int WINDOW_CYCLES = DEF_WINDOW_CYCLES,
  parameter int BPM_LOW       = DEF_BPM_LOW,
  parameter int BPM_HIGH      = DEF_BPM_HIGH,
  parameter int REMIND_PERIOD = DEF_REMIND_PERIOD,
  parameter int REMIND_WIDTH  = DEF_REMIND_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fall_detector,
  input  logic             mono_pulse,
  output logic             fall_state,
  output logic [BPM_W-1:0] bpm,
  output logic             bpm_state,
  output logic             medicine_reminder
);

  localparam int HIGH_W = $clog2(FALL_CYCLES + 1);
  localparam int HOLD_W = $clog2(FALL_HOLD + 1);
  localparam int REM_W  = (REMIND_PERIOD > 1) ? $clog2(REMIND_PERIOD) : 1;

  localparam logic [HIGH_W-1:0] HIGH_SAT = HIGH_W'(FALL_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(FALL_HOLD);
  localparam logic [REM_W-1:0]  REM_LAST = REM_W'(REMIND_PERIOD - 1);
  localparam logic [REM_W-1:0]  REM_ON   = REM_W'(REMIND_PERIOD - REMIND_WIDTH);

  // Fall detection
  logic [HIGH_W-1:0] high_cnt;
  logic [HIGH_W-1:0] high_next;
  logic [HOLD_W-1:0] hold_cnt;
  logic [HOLD_W-1:0] hold_next;
  logic              qualified;
  logic              fall_next;

  // The hold is reloaded on every cycle the sensor is qualified, so it only
  // starts running down once the sustained assertion ends; a new qualifying
  // assertion during the hold simply reloads it.
  always_comb begin
    high_next = '0;
    hold_next = '0;
    qualified = (high_cnt == HIGH_SAT);
    if (fall_detector) begin
      high_next = qualified ? high_cnt : high_cnt + HIGH_W'(1);
    end
    if (qualified) begin
      hold_next = HOLD_MAX;
    end else if (hold_cnt != '0) begin
      hold_next = hold_cnt - HOLD_W'(1);
    end
    fall_next = qualified || (hold_cnt != '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      high_cnt   <= '0;
      hold_cnt   <= '0;
      fall_state <= 1'b0;
    end else begin
      high_cnt   <= high_next;
      hold_cnt   <= hold_next;
      fall_state <= fall_next;
    end
  end

  // Medicine reminder: the registered compare makes the pulse occupy the
  // last REMIND_WIDTH cycles of each period, shifted by one clock.
  logic [REM_W-1:0] rem_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rem_cnt           <= '0;
      medicine_reminder <= 1'b0;
    end else begin
      rem_cnt           <= (rem_cnt == REM_LAST) ? '0 : rem_cnt + REM_W'(1);
      medicine_reminder <= (rem_cnt >= REM_ON);
    end
  end

  // Heartbeat-rate estimator
  bpm_window_counter #(
    .WINDOW_CYCLES (WINDOW_CYCLES),
    .BPM_LOW       (BPM_LOW),
    .BPM_HIGH      (BPM_HIGH)
  ) u_bpm (
    .clk        (clk),
    .reset      (reset),
    .mono_pulse (mono_pulse),
    .bpm        (bpm),
    .bpm_state  (bpm_state)
  );

endmodule

// File: tb/tb_elder_vitals_core.sv
// Self-checking bench for elder_vitals_core. A sample-history model derives
// every output from the recorded input samples since the last reset release;
// a negedge process compares all outputs against it every cycle, and the
// directed scenarios add literal expectations.
module tb_elder_vitals_core;
  import elder_vitals_pkg::*;

  localparam int HIST = 8192;

  // Clock and reset
  logic clk = 1'b0;
  logic reset;
  logic fall_detector;
  logic mono_pulse;
  logic fall_state;
  logic [BPM_W-1:0] bpm;
  logic bpm_state;
  logic medicine_reminder;

  always #5 clk = ~clk;

  elder_vitals_core dut (
    .clk               (clk),
    .reset             (reset),
    .fall_detector     (fall_detector),
    .mono_pulse        (mono_pulse),
    .fall_state        (fall_state),
    .bpm               (bpm),
    .bpm_state         (bpm_state),
    .medicine_reminder (medicine_reminder)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: actual %0d expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Reference model: input history indexed by clock edge since release
  int cyc = 0;
  bit fh [0:HIST-1];
  bit mh [0:HIST-1];

  initial begin
    for (int i = 0; i < HIST; i++) begin
      fh[i] = 1'b0;
      mh[i] = 1'b0;
    end
  end

  always @(posedge clk) begin
    if (reset === 1'b1) begin
      cyc = cyc + 1;
      if (cyc < HIST) begin
        fh[cyc] = fall_detector;
        mh[cyc] = mono_pulse;
      end
    end else begin
      cyc = 0;
    end
  end

  always @(negedge reset) cyc = 0;

  // Alarm after edge e: some sample j within the last FALL_HOLD+1 samples
  // ended a run of at least DEF_FALL_CYCLES consecutive high samples.
  function automatic bit exp_fall(input int e);
    for (int j = e - 1; j >= e - 1 - DEF_FALL_HOLD; j--) begin
      if (j >= DEF_FALL_CYCLES) begin
        bit run = 1'b1;
        for (int k = 0; k < DEF_FALL_CYCLES; k++) run = run & fh[j - k];
        if (run) return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  function automatic int exp_bpm(input int e);
    int w;
    int n;
    if (e < DEF_WINDOW_CYCLES) return 0;
    w = e / DEF_WINDOW_CYCLES;
    n = 0;
    for (int s = (w - 1) * DEF_WINDOW_CYCLES + 1; s <= w * DEF_WINDOW_CYCLES; s++) begin
      if (mh[s] && !mh[s - 1]) n++;
    end
    return (n > 31) ? 31 : n;
  endfunction

  function automatic bit exp_bpm_state(input int e);
    int v;
    if (e < DEF_WINDOW_CYCLES) return 1'b0;
    v = exp_bpm(e);
    return (v < DEF_BPM_LOW) || (v > DEF_BPM_HIGH);
  endfunction

  function automatic bit exp_rem(input int e);
    if (e < 1) return 1'b0;
    return ((e - 1) % DEF_REMIND_PERIOD) >= (DEF_REMIND_PERIOD - DEF_REMIND_WIDTH);
  endfunction

  // Scoreboard: compare every cycle on the falling edge
  always @(negedge clk) begin
    if (reset !== 1'b1) begin
      check("rst_fall_state", {31'd0, fall_state}, 32'd0);
      check("rst_bpm", {27'd0, bpm}, 32'd0);
      check("rst_bpm_state", {31'd0, bpm_state}, 32'd0);
      check("rst_reminder", {31'd0, medicine_reminder}, 32'd0);
    end else if (cyc < HIST) begin
      check("fall_state", {31'd0, fall_state}, {31'd0, exp_fall(cyc)});
      check("bpm", {27'd0, bpm}, exp_bpm(cyc));
      check("bpm_state", {31'd0, bpm_state}, {31'd0, exp_bpm_state(cyc)});
      check("reminder", {31'd0, medicine_reminder}, {31'd0, exp_rem(cyc)});
    end
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic align_window();
    while ((cyc % DEF_WINDOW_CYCLES) != 0) step();
  endtask

  task automatic fall_run(input int len, input int n, input string name);
    for (int k = 1; k <= n; k++) begin
      fall_detector = (k <= len);
      step();
      check(name, {31'd0, fall_state}, {31'd0, (len >= 3) && (k >= 4) && (k <= len + 5)});
    end
    fall_detector = 1'b0;
  endtask

  task automatic bpm_window(input int pulses, input int want_bpm, input bit want_state);
    align_window();
    for (int i = 0; i < DEF_WINDOW_CYCLES; i++) begin
      mono_pulse = (i < 2 * pulses) && ((i % 2) == 0);
      step();
    end
    mono_pulse = 1'b0;
    check("bpm_lit", {27'd0, bpm}, want_bpm);
    check("bpm_state_lit", {31'd0, bpm_state}, {31'd0, want_state});
  endtask

  task automatic idle_after_release(input string tag);
    for (int k = 1; k <= 201; k++) begin
      step();
      check({tag, "_idle_fall"}, {31'd0, fall_state}, 32'd0);
      if (k == 90 || k == 91 || k == 100 || k == 101 ||
          k == 190 || k == 191 || k == 200 || k == 201) begin
        check({tag, "_remind"}, {31'd0, medicine_reminder},
              {31'd0, ((k >= 91) && (k <= 100)) || ((k >= 191) && (k <= 200))});
      end
      if (k == 63) check({tag, "_bpm_state_pre"}, {31'd0, bpm_state}, 32'd0);
      if (k == 64) begin
        check({tag, "_bpm_first"}, {27'd0, bpm}, 32'd0);
        check({tag, "_bpm_state_first"}, {31'd0, bpm_state}, 32'd1);
      end
    end
  endtask

  // Stimulus
  initial begin
    reset = 1'b0;
    fall_detector = 1'b0;
    mono_pulse = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("reset_fall_state", {31'd0, fall_state}, 32'd0);
    check("reset_bpm", {27'd0, bpm}, 32'd0);
    check("reset_bpm_state", {31'd0, bpm_state}, 32'd0);
    check("reset_reminder", {31'd0, medicine_reminder}, 32'd0);
    reset = 1'b1;
    idle_after_release("first");

    // Fall duration: short glitch versus sustained assertion
    fall_run(2, 12, "fall_glitch");
    fall_run(5, 14, "fall_long");

    // BPM windows
    bpm_window(12, 12, 1'b0);
    bpm_window(3, 3, 1'b1);
    bpm_window(25, 25, 1'b1);
    bpm_window(32, 31, 1'b1);

    // Pulse held high across a window boundary is counted once
    align_window();
    for (int i = 0; i < 72; i++) begin
      mono_pulse = (i >= 60) && (i < 68);
      step();
      if (i == DEF_WINDOW_CYCLES - 1) begin
        check("span_bpm_a", {27'd0, bpm}, 32'd1);
        check("span_state_a", {31'd0, bpm_state}, 32'd1);
      end
    end
    mono_pulse = 1'b0;
    align_window();
    check("span_bpm_b", {27'd0, bpm}, 32'd0);

    // Randomized segments with varying heart rate and bursty fall sensor
    for (int seg = 0; seg < 12; seg++) begin
      int rate;
      int frate;
      rate = $urandom_range(1, 12);
      frate = $urandom_range(1, 6);
      for (int i = 0; i < 128; i++) begin
        if ($urandom_range(0, rate) == 0) mono_pulse = ~mono_pulse;
        if ($urandom_range(0, frate) == 0) fall_detector = ~fall_detector;
        step();
      end
    end
    fall_detector = 1'b0;
    mono_pulse = 1'b0;

    // Mid-operation reset during a reminder pulse
    while ((cyc % DEF_REMIND_PERIOD) != 95) step();
    check("reminder_before_reset", {31'd0, medicine_reminder}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("async_fall_state", {31'd0, fall_state}, 32'd0);
    check("async_bpm", {27'd0, bpm}, 32'd0);
    check("async_bpm_state", {31'd0, bpm_state}, 32'd0);
    check("async_reminder", {31'd0, medicine_reminder}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    idle_after_release("restart");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
